ppu_fb_writer: RTL and testbench

- Sits directly downstream of the PPU pixel FIFO. Consumes the 2-bit colour indices and valid strobe, maps each index through the BGP palette, and packs 4 shades per byte.
- Writes packed lines into a 2bpp 160x144 frame buffer RAM, with optional double buffering.
- The display/VGA side reads the bank not being written and uses frame_done for frame sync.

---
 rtl/ppu_pkg.sv | 35 +++
 rtl/ppu_fb_writer_packer.sv | 73 +++++++
 rtl/ppu_fb_writer.sv | 147 ++++++++++++++
 tb/tb_ppu_fb_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and frame buffer geometry used by the PPU and the frame buffer writer.
package ppu_pkg;

    localparam int unsigned LCD_W         = 160;
    localparam int unsigned LCD_H         = 144;
    localparam int unsigned FB_LINE_BYTES = LCD_W / 4;
    localparam int unsigned FB_BANK_BYTES = LCD_H * FB_LINE_BYTES;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [2:0] {
        OFF,
        WAIT_DRAW,
        ACTIVE,
        FLUSH,
        VBLANK
    } FB_WR_STATES_t;

    // Byte address of column col (4 pixels per byte) on a given line and bank.
    function automatic logic [31:0] fb_byte_addr(input logic        bank,
                                                 input logic [7:0]  line,
                                                 input logic [5:0]  col,
                                                 input int unsigned line_bytes,
                                                 input int unsigned bank_bytes);
        logic [31:0] base;
        base = bank ? bank_bytes : 32'd0;
        return base + 32'(line) * line_bytes + 32'(col);
    endfunction

endpackage

// File: rtl/ppu_fb_writer_packer.sv
// Palette lookup and 2bpp packing of one line of pixels; flags full bytes and
// the partial byte left over at end of line.
module ppu_px_packer #(
    parameter int unsigned LCD_W = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       accept_i,
    input  logic       flush_i,
    input  logic [1:0] px_i,
    input  logic [7:0] bgp_i,
    output logic       byte_done_o,
    output logic [7:0] byte_data_o,
    output logic       flush_we_o,
    output logic [7:0] flush_data_o,
    output logic [5:0] col_o
);

    logic [7:0] x_q, x_d;
    logic [7:0] pack_q, pack_d;
    logic [1:0] shade;
    logic       take;

    always_comb begin
        unique case (px_i)
            2'd0:    shade = bgp_i[1:0];
            2'd1:    shade = bgp_i[3:2];
            2'd2:    shade = bgp_i[5:4];
            default: shade = bgp_i[7:6];
        endcase
    end

    // Pixels beyond the visible width are swallowed; x parks at LCD_W.
    assign take         = accept_i && (32'(x_q) < LCD_W);
    assign byte_data_o  = {pack_q[5:0], shade};
    assign byte_done_o  = take && (x_q[1:0] == 2'd3);
    assign col_o        = x_q[7:2];
    assign flush_we_o   = flush_i && (x_q[1:0] != 2'd0);

    // Left-justify the pixels already shifted in; unfilled positions read as 0.
    always_comb begin
        unique case (x_q[1:0])
            2'd1:    flush_data_o = {pack_q[1:0], 6'b0};
            2'd2:    flush_data_o = {pack_q[3:0], 4'b0};
            2'd3:    flush_data_o = {pack_q[5:0], 2'b0};
            default: flush_data_o = 8'h00;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        pack_d = pack_q;
        if (clr_i || flush_i) begin
            x_d    = 8'd0;
            pack_d = 8'h00;
        end else if (take) begin
            x_d    = x_q + 8'd1;
            pack_d = byte_data_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= 8'd0;
            pack_q <= 8'h00;
        end else begin
            x_q    <= x_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/ppu_fb_writer.sv
// Frame buffer writer: sequences lines and frames from the PPU mode, generates
// byte addresses and (optionally) flips between two frame buffer banks.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int unsigned LCD_W      = 160,
    parameter int unsigned LCD_H      = 144,
    parameter bit          DOUBLE_BUF = 1'b1,
    parameter int unsigned FB_AW      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_en,
    input  logic [1:0]       ppu_mode,
    input  logic [1:0]       px_in,
    input  logic             px_valid,
    input  logic [7:0]       bgp,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_wdata,
    output logic             fb_bank,
    output logic             frame_done,
    output logic [7:0]       line_cnt
);

    localparam int unsigned LINE_BYTES = LCD_W / 4;
    localparam int unsigned BANK_BYTES = LCD_H * LINE_BYTES;

    PPU_STATES_t      mode;
    FB_WR_STATES_t    state_q, state_d;
    logic [7:0]       line_q, line_d, line_inc;
    logic             bank_q, bank_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]       fb_wdata_q, fb_wdata_d;
    logic             frame_done_q, frame_done_d;
    logic             enter_vblank;
    logic             clr, accept, flush;
    logic             byte_done, flush_we;
    logic [7:0]       byte_data, flush_data;
    logic [5:0]       col;

    assign mode     = PPU_STATES_t'(ppu_mode);
    assign clr      = rst || !lcd_en;
    assign accept   = (state_q == ACTIVE) && px_valid;
    assign flush    = (state_q == FLUSH);
    assign line_inc = line_q + 8'd1;

    ppu_px_packer #(
        .LCD_W (LCD_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .accept_i     (accept),
        .flush_i      (flush),
        .px_i         (px_in),
        .bgp_i        (bgp),
        .byte_done_o  (byte_done),
        .byte_data_o  (byte_data),
        .flush_we_o   (flush_we),
        .flush_data_o (flush_data),
        .col_o        (col)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        bank_d       = bank_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        frame_done_d = 1'b0;
        enter_vblank = 1'b0;

        unique case (state_q)
            OFF:       state_d = WAIT_DRAW;
            WAIT_DRAW: begin
                if (mode == DRAW) begin
                    state_d = ACTIVE;
                end else if (mode == V_BLANK && line_q != 8'd0) begin
                    enter_vblank = 1'b1;
                end
            end
            ACTIVE:    if (mode != DRAW) state_d = FLUSH;
            FLUSH: begin
                line_d = line_inc;
                if (32'(line_inc) == LCD_H) enter_vblank = 1'b1;
                else                        state_d = WAIT_DRAW;
            end
            VBLANK:    if (mode == SCAN || mode == DRAW) state_d = WAIT_DRAW;
            default:   state_d = OFF;
        endcase

        // Single entry point into VBLANK keeps frame_done to one pulse per frame.
        if (enter_vblank) begin
            state_d      = VBLANK;
            frame_done_d = 1'b1;
            line_d       = 8'd0;
            bank_d       = DOUBLE_BUF ? ~bank_q : 1'b0;
        end

        if (byte_done || flush_we) begin
            fb_we_d    = 1'b1;
            fb_wdata_d = byte_done ? byte_data : flush_data;
            fb_addr_d  = FB_AW'(fb_byte_addr(bank_q, line_q, col, LINE_BYTES, BANK_BYTES));
        end

        if (!lcd_en) begin
            state_d      = OFF;
            line_d       = 8'd0;
            bank_d       = 1'b0;
            fb_we_d      = 1'b0;
            fb_addr_d    = '0;
            fb_wdata_d   = 8'h00;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            line_q       <= 8'd0;
            bank_q       <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            bank_q       <= bank_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign fb_bank    = bank_q;
    assign frame_done = frame_done_q;
    assign line_cnt   = line_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: line packing, palette, flush, overrun,
// abort and double-buffered frame wrap.
module tb_ppu_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_en;
    logic [1:0]  ppu_mode;
    logic [1:0]  px_in;
    logic        px_valid;
    logic [7:0]  bgp;
    logic        fb_we;
    logic [13:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_bank;
    logic        frame_done;
    logic [7:0]  line_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int          fd_total  = 0;
    int          fd_wr_pos = 0;
    int          base;
    int          fd_base;

    always #5 clk = ~clk;

    ppu_fb_writer #(
        .LCD_W      (160),
        .LCD_H      (144),
        .DOUBLE_BUF (1'b1),
        .FB_AW      (14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_en     (lcd_en),
        .ppu_mode   (ppu_mode),
        .px_in      (px_in),
        .px_valid   (px_valid),
        .bgp        (bgp),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_bank    (fb_bank),
        .frame_done (frame_done),
        .line_cnt   (line_cnt)
    );

    // Write/pulse logger; all checking happens in the stimulus block.
    always @(negedge clk) begin
        if (fb_we) begin
            wa.push_back(32'(fb_addr));
            wd.push_back(fb_wdata);
        end
        if (frame_done) begin
            fd_total  <= fd_total + 1;
            fd_wr_pos <= wa.size();
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: px = i%4, kind 1: px = cval. bgp switches to bgb from pixel sw_at.
    task automatic run_line(input int n, input int kind, input logic [1:0] cval,
                            input int sw_at, input logic [7:0] bga, input logic [7:0] bgb,
                            input bit overlap);
        px_valid = 1'b0;
        ppu_mode = 2'd2;
        step();
        ppu_mode = 2'd3;
        step();
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            px_in    = (kind == 0) ? 2'(i % 4) : cval;
            bgp      = (i >= sw_at) ? bgb : bga;
            if (overlap && i == n - 1) ppu_mode = 2'd0;
            step();
        end
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        repeat (3) step();
    endtask

    initial begin
        rst      = 1'b1;
        lcd_en   = 1'b1;
        ppu_mode = 2'd0;
        px_in    = 2'd0;
        px_valid = 1'b0;
        bgp      = 8'hE4;
        repeat (3) step();
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_wdata", 32'(fb_wdata), 32'd0);
        check("rst_bank", 32'(fb_bank), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_line", 32'(line_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Line 0: 0,1,2,3 pattern with identity palette.
        base = wa.size();
        run_line(160, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("pack_count", 32'(wa.size() - base), 32'd40);
        for (int i = 0; i < 40; i++) begin
            check("pack_addr", wa[base + i], 32'(i));
            check("pack_data", 32'(wd[base + i]), 32'h1B);
        end
        check("pack_line", 32'(line_cnt), 32'd1);

        // Line 1: inverted palette, then palette change at pixel 80.
        base = wa.size();
        run_line(160, 1, 2'd0, 80, 8'h1B, 8'hE4, 1'b0);
        check("pal_count", 32'(wa.size() - base), 32'd40);
        for (int i = 0; i < 40; i++) begin
            check("pal_addr", wa[base + i], 32'(40 + i));
            check("pal_data", 32'(wd[base + i]), (i < 20) ? 32'hFF : 32'h00);
        end

        // Line 2: 150 pixels -> 37 full bytes plus a 2-pixel flush.
        base = wa.size();
        run_line(150, 1, 2'd3, 1000, 8'hE4, 8'hE4, 1'b0);
        check("part_count", 32'(wa.size() - base), 32'd38);
        check("part_full_last", 32'(wd[base + 36]), 32'hFF);
        check("part_flush_addr", wa[base + 37], 32'd117);
        check("part_flush_data", 32'(wd[base + 37]), 32'hF0);

        // Line 3: 168 pixels, overrun dropped.
        base = wa.size();
        run_line(168, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("ovr_count", 32'(wa.size() - base), 32'd40);
        check("ovr_last_addr", wa[base + 39], 32'd159);
        check("ovr_last_data", 32'(wd[base + 39]), 32'h1B);

        // Line 4: byte completes in the same cycle mode leaves DRAW.
        base = wa.size();
        run_line(8, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b1);
        check("sim_count", 32'(wa.size() - base), 32'd2);
        check("sim_addr", wa[base + 1], 32'd161);
        check("sim_data", 32'(wd[base + 1]), 32'h1B);
        check("sim_line", 32'(line_cnt), 32'd5);

        // Line 5: abort after 6 pixels.
        base = wa.size();
        ppu_mode = 2'd2;
        step();
        ppu_mode = 2'd3;
        step();
        for (int i = 0; i < 6; i++) begin
            px_valid = 1'b1;
            px_in    = 2'(i % 4);
            step();
        end
        lcd_en   = 1'b0;
        px_valid = 1'b0;
        repeat (2) step();
        check("abort_count", 32'(wa.size() - base), 32'd1);
        check("abort_addr", wa[base], 32'd200);
        check("abort_line", 32'(line_cnt), 32'd0);
        check("abort_bank", 32'(fb_bank), 32'd0);
        check("abort_we", 32'(fb_we), 32'd0);
        lcd_en = 1'b1;
        base = wa.size();
        run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("reen_count", 32'(wa.size() - base), 32'd1);
        check("reen_addr", wa[base], 32'd0);

        // Frame wrap with double buffering.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        base    = wa.size();
        fd_base = fd_total;
        for (int l = 0; l < 143; l++) run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("frm_no_early_fd", 32'(fd_total - fd_base), 32'd0);
        check("frm_line143", 32'(line_cnt), 32'd143);
        run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("frm_fd_once", 32'(fd_total - fd_base), 32'd1);
        check("frm_fd_after_last", 32'(fd_wr_pos - base), 32'd144);
        check("frm_last_addr", wa[base + 143], 32'd5720);
        check("frm_bank1", 32'(fb_bank), 32'd1);
        check("frm_line0", 32'(line_cnt), 32'd0);
        ppu_mode = 2'd1;
        repeat (10) step();
        check("frm_vblank_hold", 32'(fd_total - fd_base), 32'd1);
        base = wa.size();
        run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("frm2_addr", wa[base], 32'd5760);
        for (int l = 1; l < 144; l++) run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("frm2_fd", 32'(fd_total - fd_base), 32'd2);
        check("frm2_last_addr", wa[base + 143], 32'd11480);
        check("frm2_bank0", 32'(fb_bank), 32'd0);
        base = wa.size();
        run_line(4, 0, 2'd0, 1000, 8'hE4, 8'hE4, 1'b0);
        check("frm3_addr", wa[base], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
